centroid_divider_seq: RTL and testbench
=======================================

# centroid_divider_seq

Time-multiplexed centroid divider for the K-means update stage: divides per-cluster accumulated pixel-component sums by per-cluster pixel counts for `NUM_CH` channels using one shared iterative divider. It replaces the fully parallel 16-divider bank with a parametrised, area-cheap engine. It adds a start/done handshake, enabled-channel skipping, divide-by-zero flagging and registered quotient outputs. It sits between the cluster accumulators and the centroid register file.

## Interface
- `NUM_CH`, 16, number of channels (clusters × components); ≥1.
- `DIVIDEND_W`, 20, accumulated-sum width; also the quotient width.
- `DIVISOR_W`, 12, pixel-count width; ≤ `DIVIDEND_W`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: clock enable. When low, all state, counters and outputs are frozen and `start` is ignored.
- `start` in 1: request a new pass. Accepted only in IDLE with `ce`=1.
- `en` in `NUM_CH`: channel enable mask, sampled with `start`.
- `dividend_flat` in `NUM_CH*DIVIDEND_W`: channel i is at bits [i*DIVIDEND_W +: DIVIDEND_W], sampled with `start`.
- `divisor_flat` in `NUM_CH*DIVISOR_W`: same packing, sampled with `start`.
- `busy` out 1: high from the cycle after acceptance through DONE.
- `done` out 1: one-cycle pulse at the end of a pass.
- `all_ready` out 1: level. Set in DONE, cleared when the next `start` is accepted.
- `dbz` out `NUM_CH`: per-channel flag, high if the channel was enabled with divisor 0 in the last pass.
- `q_flat` out `NUM_CH*DIVIDEND_W`: registered quotients, same packing as `dividend_flat`.
- Reset values: `busy`, `done`, `all_ready` = 0; `dbz` = 0; `q_flat` = 0; FSM in IDLE.

## Operation
- FSM states: IDLE, SELECT, DIV, STORE, DONE.
- IDLE:
  - On `start`, latch `en`, all dividends and all divisors.
  - Clear `all_ready`, clear `dbz`, set `ch_idx`=0, go to SELECT.
- SELECT (1 cycle per channel), evaluates channel `ch_idx`:
  - Disabled channel: `q` and `dbz` unchanged; advance.
  - Enabled channel with divisor 0: set `dbz[ch_idx]`, `q` holds its previous value (an empty cluster keeps its old centroid); advance.
  - Enabled channel with nonzero divisor: load the divider core and go to DIV.
  - Advance means: go to SELECT with `ch_idx`+1, or to DONE if `ch_idx`=`NUM_CH`-1.
- DIV: restoring divide, one quotient bit per cycle, `ITER` cycles.
  - `ITER` = `DIVIDEND_W` (truncating build) or `DIVIDEND_W`+1 (rounding build).
- STORE (1 cycle): write the quotient to `q[ch_idx]`, then advance as in SELECT.
- DONE (1 cycle): `done`=1 and `all_ready` set, then return to IDLE.
- Arithmetic:
  - The quotient is unsigned and truncated toward zero (rounding variant in Configuration).
  - The divisor is zero-extended to the dividend width.
  - The remainder is discarded.
- Boundary conditions:
  - `start` while not in IDLE is ignored, with no effect on the latched inputs.
  - `en`=0 still walks all channels; `q` is untouched.
  - `reset` mid-pass returns to IDLE and applies the reset values on the next edge.
  - Input changes after acceptance have no effect.

## Timing
- With `start` accepted at edge T and E channels actually divided (enabled, nonzero divisor), `done` is high in cycle T+1+`NUM_CH`+E*(`ITER`+1).
- `q[i]` is visible the cycle after its STORE; every `q` is final when `done` asserts.
- `all_ready` rises together with `done`.
- The earliest next accepted `start` is in the cycle after `done`.
- Each cycle with `ce`=0 adds exactly one cycle to the latency.

## Configuration
- `CENTROID_DIV_ROUND_EN` defined:
  - The dividend is extended to `DIVIDEND_W`+1 bits and `divisor>>1` is added before dividing, giving round-half-up.
  - `ITER` = `DIVIDEND_W`+1.
  - The quotient always fits in `DIVIDEND_W` bits, so no saturation logic is needed.
- Undefined: truncating division with `ITER` = `DIVIDEND_W`.

## Structure
- Package `centroid_div_pkg` holds:
  - the FSM state enum;
  - default parameter constants;
  - the `ITER` function of `DIVIDEND_W` and the macro.
- One sub-module, `seq_divider_core`, a restoring one-bit-per-cycle divider with ports `load`, `busy`, `quotient`.
- The top level holds the input latches, FSM, channel counter and result registers.

## Test plan
All scenarios use `NUM_CH`=4, `DIVIDEND_W`=20, `DIVISOR_W`=12, truncating build unless noted.
- `en`=1111; dividends 1000, 255, 1048575, 7; divisors 10, 1, 4095, 8 -> `q` = 100, 255, 256, 0; `dbz`=0000; `done` at T+89.
- Then `en`=0101; ch0 1000/10; ch2 divisor 0 -> `q0`=100, `q2` stays 256, `dbz`=0100, `done` at T+26.
- `en`=0000 -> `done` at T+5, `q` unchanged, `all_ready`=1.
- `start` re-pulsed during DIV, plus `ce` low for 5 cycles -> pass unaffected, `done` delayed by exactly 5.
- `reset` asserted mid-DIV -> next cycle `busy`=0, `all_ready`=0, `q`=0; a fresh `start` completes normally.
- Rounding build, same stimulus as the first scenario -> `q` = 100, 255, 256, 1; `done` at T+93.

Source files
------------

// File: rtl/centroid_div_pkg.sv
// Shared types and constants for the time-multiplexed centroid divider.
// CENTROID_DIV_ROUND_EN selects round-half-up quotients (one extra iteration).
package centroid_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_DIV,
    S_STORE,
    S_DONE
  } state_e;

  localparam int DEF_NUM_CH     = 16;
  localparam int DEF_DIVIDEND_W = 20;
  localparam int DEF_DIVISOR_W  = 12;

  // Rounding widens the dividend by one bit, so the core needs one more step.
  function automatic int iter_of(input int dw);
`ifdef CENTROID_DIV_ROUND_EN
    return dw + 1;
`else
    return dw;
`endif
  endfunction

endpackage

// File: rtl/seq_divider_core.sv
// Restoring unsigned divider, one quotient bit per enabled cycle.
// N is both the dividend/quotient width and the iteration count.
module seq_divider_core #(
  parameter int N = 20
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ce,
  input  logic         i_load,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic [N-1:0] o_quotient
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] r_cnt;
  logic [N:0]    r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_dvs;

  logic [N:0]    w_tmp;
  logic [N:0]    w_diff;
  logic          w_ge;

  assign w_tmp  = {r_rem[N-1:0], r_quo[N-1]};
  assign w_ge   = (w_tmp >= {1'b0, r_dvs});
  assign w_diff = w_tmp - {1'b0, r_dvs};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_ce) begin
      if (i_load) begin
        r_cnt <= CW'(N);
        r_rem <= '0;
        r_quo <= i_dividend;
        r_dvs <= i_divisor;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
        r_rem <= w_ge ? w_diff : w_tmp;
        r_quo <= (r_quo << 1) | N'(w_ge);
      end
    end
  end

  // Drops during the final step so the caller leaves its wait state with no idle cycle.
  assign o_busy     = (r_cnt > CW'(1));
  assign o_quotient = r_quo;

endmodule

// File: rtl/centroid_divider_seq.sv
// Walks NUM_CH channels through one shared iterative divider, flagging divide-by-zero.
// Define CENTROID_DIV_ROUND_EN for round-half-up quotients; default truncates.
module centroid_divider_seq
  import centroid_div_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_ce,
  input  logic                           i_start,
  input  logic [NUM_CH-1:0]              i_en,
  input  logic [NUM_CH*DIVIDEND_W-1:0]   i_dividend_flat,
  input  logic [NUM_CH*DIVISOR_W-1:0]    i_divisor_flat,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_all_ready,
  output logic [NUM_CH-1:0]              o_dbz,
  output logic [NUM_CH*DIVIDEND_W-1:0]   o_q_flat
);

  localparam int ITER = iter_of(DIVIDEND_W);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e r_state, w_state_nxt;

  logic [NUM_CH-1:0]                 r_en;
  logic [NUM_CH-1:0]                 r_dbz;
  logic [NUM_CH-1:0][DIVIDEND_W-1:0] r_dvd;
  logic [NUM_CH-1:0][DIVIDEND_W-1:0] r_q;
  logic [NUM_CH-1:0][DIVISOR_W-1:0]  r_dvs;
  logic [CH_W-1:0]                   r_ch;
  logic                              r_all_ready;

  logic            w_accept, w_sel_en, w_sel_zero, w_last_ch;
  logic            w_core_load, w_core_busy, w_advance;
  logic [ITER-1:0] w_core_dvd, w_core_dvs, w_core_quo;

  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_sel_en   = r_en[r_ch];
  assign w_sel_zero = (r_dvs[r_ch] == '0);
  assign w_last_ch  = (r_ch == LAST_CH);

`ifdef CENTROID_DIV_ROUND_EN
  assign w_core_dvd = ITER'(r_dvd[r_ch]) + ITER'(r_dvs[r_ch] >> 1);
`else
  assign w_core_dvd = ITER'(r_dvd[r_ch]);
`endif
  assign w_core_dvs = ITER'(r_dvs[r_ch]);

  seq_divider_core #(.N(ITER)) u_core (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ce       (i_ce),
    .i_load     (w_core_load),
    .i_dividend (w_core_dvd),
    .i_divisor  (w_core_dvs),
    .o_busy     (w_core_busy),
    .o_quotient (w_core_quo)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset)   r_state <= S_IDLE;
    else if (i_ce) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_SELECT;
      S_SELECT: begin
        if (w_sel_en && !w_sel_zero) w_state_nxt = S_DIV;
        else if (w_last_ch)          w_state_nxt = S_DONE;
      end
      S_DIV:    if (!w_core_busy) w_state_nxt = S_STORE;
      S_STORE:  w_state_nxt = w_last_ch ? S_DONE : S_SELECT;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
    w_core_load = (r_state == S_SELECT) && w_sel_en && !w_sel_zero;
    w_advance   = ((r_state == S_SELECT) && !w_core_load) || (r_state == S_STORE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_en        <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_ch        <= '0;
      r_q         <= '0;
      r_dbz       <= '0;
      r_all_ready <= 1'b0;
    end else if (i_ce) begin
      if (w_accept) begin
        r_en        <= i_en;
        r_dvd       <= i_dividend_flat;
        r_dvs       <= i_divisor_flat;
        r_dbz       <= '0;
        r_all_ready <= 1'b0;
        r_ch        <= '0;
      end
      // Empty cluster: flag it and keep the previous centroid.
      if ((r_state == S_SELECT) && w_sel_en && w_sel_zero) r_dbz[r_ch] <= 1'b1;
      if (r_state == S_STORE) r_q[r_ch] <= w_core_quo[DIVIDEND_W-1:0];
      if (w_advance && !w_last_ch) r_ch <= r_ch + CH_W'(1);
      if (w_state_nxt == S_DONE) r_all_ready <= 1'b1;
    end
  end

  assign o_all_ready = r_all_ready;
  assign o_dbz       = r_dbz;
  assign o_q_flat    = r_q;

endmodule

// File: tb/tb_centroid_divider_seq.sv
// Directed bench for centroid_divider_seq (NUM_CH=4): scoreboard of expected
// quotients, dbz flags and done latency, checked when done pulses.
module tb_centroid_divider_seq;

`ifdef CENTROID_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int ITER_TB = 20 + RND;

  typedef struct {
    logic [3:0][19:0] q;
    logic [3:0]       dbz;
    int               lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ce = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        en = '0;
  logic [3:0][19:0]  dvd = '0;
  logic [3:0][11:0]  dvs = '0;
  logic              busy, done, all_ready;
  logic [3:0]        dbz;
  logic [3:0][19:0]  q;

  int               cyc = 0;
  int               t_acc = 0;
  int               total = 0;
  int               bad = 0;
  logic [3:0][19:0] qm = '0;
  exp_t             sbq[$];

  centroid_divider_seq #(.NUM_CH(4), .DIVIDEND_W(20), .DIVISOR_W(12)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_ce            (ce),
    .i_start         (start),
    .i_en            (en),
    .i_dividend_flat (dvd),
    .i_divisor_flat  (dvs),
    .o_busy          (busy),
    .o_done          (done),
    .o_all_ready     (all_ready),
    .o_dbz           (dbz),
    .o_q_flat        (q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start_pass(input logic [3:0] e, input logic [3:0][19:0] d,
                            input logic [3:0][11:0] v);
    exp_t x;
    int nd;
    logic [20:0] add;
    nd    = 0;
    x.dbz = '0;
    for (int i = 0; i < 4; i++) begin
      if (e[i]) begin
        if (v[i] == 12'd0) x.dbz[i] = 1'b1;
        else begin
          add   = (RND != 0) ? 21'(v[i] >> 1) : 21'd0;
          qm[i] = 20'((21'(d[i]) + add) / 21'(v[i]));
          nd++;
        end
      end
    end
    x.q   = qm;
    x.lat = 1 + 4 + nd * (ITER_TB + 1);
    en = e; dvd = d; dvs = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t_acc = cyc;
    sbq.push_back(x);
    chk("acc_busy", 64'(busy), 64'd1);
    chk("acc_all_ready", 64'(all_ready), 64'd0);
    chk("acc_dbz", 64'(dbz), 64'd0);
  endtask

  task automatic wait_done(input int pulse_at, input int ce_at, input int ce_n);
    exp_t x;
    int   k;
    bit   got;
    got = 1'b0;
    for (int n = 0; n < 600 && !got; n++) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        k = cyc - t_acc + 1;
        start = (k == pulse_at);
        if (k == pulse_at) begin
          en = ~en;
          for (int i = 0; i < 4; i++) begin
            dvd[i] = 20'($urandom);
            dvs[i] = 12'($urandom);
          end
        end
        ce = !(k >= ce_at && k < ce_at + ce_n);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    ce    = 1'b1;
    chk("done_seen", 64'(got), 64'd1);
    if (sbq.size() == 0) chk("sb_nonempty", 64'd0, 64'd1);
    else begin
      x = sbq.pop_front();
      chk("latency", 64'(cyc - t_acc + 1), 64'(x.lat + ce_n));
      for (int i = 0; i < 4; i++) chk($sformatf("q%0d", i), 64'(q[i]), 64'(x.q[i]));
      chk("dbz", 64'(dbz), 64'(x.dbz));
      chk("done_all_ready", 64'(all_ready), 64'd1);
      chk("done_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    chk("post_done", 64'(done), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_all_ready", 64'(all_ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_all_ready", 64'(all_ready), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    chk("rst_q", 64'(q[0] | q[1] | q[2] | q[3]), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // All channels divided, including full-scale dividend and a sub-unity quotient.
    start_pass(4'b1111, {20'd7, 20'd1048575, 20'd255, 20'd1000},
                        {12'd8, 12'd4095, 12'd1, 12'd10});
    wait_done(0, 0, 0);

    // Sparse mask with an empty cluster: q2 keeps its old value.
    start_pass(4'b0101, {20'd77, 20'd0, 20'd77, 20'd1000},
                        {12'd1, 12'd0, 12'd1, 12'd10});
    wait_done(0, 0, 0);

    // Nothing enabled: bare channel walk.
    start_pass(4'b0000, {20'd5, 20'd5, 20'd5, 20'd5},
                        {12'd1, 12'd1, 12'd1, 12'd1});
    wait_done(0, 0, 0);

    // Spurious start with new inputs mid-DIV, then a 5-cycle clock-enable stall.
    start_pass(4'b1111, {20'd42, 20'd999, 20'd123456, 20'd5000},
                        {12'd0, 12'd1000, 12'd100, 12'd7});
    wait_done(10, 30, 5);

    // Reset mid-DIV discards the pass and clears results.
    start_pass(4'b1111, {20'd9, 20'd9, 20'd9, 20'd90000},
                        {12'd3, 12'd3, 12'd3, 12'd9});
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_all_ready", 64'(all_ready), 64'd0);
    chk("midrst_dbz", 64'(dbz), 64'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_q%0d", i), 64'(q[i]), 64'd0);
    void'(sbq.pop_back());
    qm = '0;

    start_pass(4'b1010, {20'd1048575, 20'd0, 20'd65535, 20'd0},
                        {12'd1, 12'd0, 12'd3, 12'd0});
    wait_done(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
